// File: rtl/signconv_serial.sv
// Bit-serial sign-magnitude <-> two's-complement converter with valid/ready on both sides.
// One magnitude bit per cycle through a conditional-invert + half-adder stage.
module signconv_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_negzero,
  output logic             out_ovf
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 2);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-2:0] a_q, a_d;
  logic [WIDTH-2:0] r_q, r_d;
  logic             s_q, s_d;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             negzero_q, negzero_d;
  logic             ovf_q, ovf_d;
  logic             t;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      r_q         <= '0;
      s_q         <= 1'b0;
      mode_q      <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      negzero_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      r_q         <= r_d;
      s_q         <= s_d;
      mode_q      <= mode_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      negzero_q   <= negzero_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CONV;
      CONV:    if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d         = a_q;
    r_d         = r_q;
    s_d         = s_q;
    mode_d      = mode_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    negzero_d   = negzero_q;
    ovf_d       = ovf_q;
    t           = a_q[0] ^ s_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_data[WIDTH-2:0];
          s_d     = in_data[WIDTH-1];
          mode_d  = in_mode;
          carry_d = in_data[WIDTH-1];
          idx_d   = '0;
        end
      end
      CONV: begin
        // LSB-first: result bits enter at the top and settle into place after WIDTH-1 shifts
        a_d             = a_q >> 1;
        r_d             = r_q >> 1;
        r_d[WIDTH-2]    = t ^ carry_q;
        carry_d         = t & carry_q;
        idx_d           = idx_q + 1'b1;
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          negzero_d   = 1'b0;
          ovf_d       = 1'b0;
          out_data_d  = {s_q, r_q};
          // A surviving carry means a negative sign over an all-zero magnitude
          if (carry_q) begin
            if (mode_q) begin
              out_data_d = '1;
              ovf_d      = 1'b1;
            end else begin
              out_data_d = '0;
              negzero_d  = 1'b1;
            end
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == IDLE) && !rst;
    out_valid   = out_valid_q;
    out_data    = out_data_q;
    out_negzero = negzero_q;
    out_ovf     = ovf_q;
  end

endmodule

// File: tb/tb_signconv_serial.sv
// Self-checking bench for signconv_serial: directed table, corner sequences,
// randomized words against an arithmetic reference, and an exhaustive 4-bit sweep.
module tb_signconv_serial;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, in_mode, out_valid, out_ready, out_negzero, out_ovf;
  logic [W-1:0] in_data, out_data;
  logic         in_valid_4, in_ready_4, in_mode_4, out_valid_4, out_ready_4, out_negzero_4, out_ovf_4;
  logic [3:0]   in_data_4, out_data_4;

  signconv_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_negzero(out_negzero), .out_ovf(out_ovf)
  );

  signconv_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_4), .in_ready(in_ready_4), .in_data(in_data_4),
    .in_mode(in_mode_4), .out_valid(out_valid_4), .out_ready(out_ready_4), .out_data(out_data_4),
    .out_negzero(out_negzero_4), .out_ovf(out_ovf_4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endfunction

  // Reference: value arithmetic on the encoded word, no bit-serial view
  function automatic longint model(input int w, input longint x, input logic m,
                                   output logic nz, output logic ov);
    longint top, full, mag;
    top  = longint'(1) << (w - 1);
    full = (longint'(1) << w) - 1;
    mag  = x & (top - 1);
    nz   = 1'b0;
    ov   = 1'b0;
    if ((x & top) == 0) return x;
    if (mag == 0) begin
      if (!m) begin nz = 1'b1; return 0; end
      ov = 1'b1;
      return full;
    end
    if (!m) return (full + 1 - mag) & full;
    return top | ((full + 1 - x) & full);
  endfunction

  task automatic run8(input logic [W-1:0] d, input logic m, input int hold,
                      input logic [W-1:0] e, input logic enz, input logic eov, input string tag);
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 20) begin @(negedge clk); cnt++; end
    chk({tag, " in_ready idle"}, in_ready, 1);
    in_data = d; in_mode = m; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_data = W'($urandom); in_mode = 1'($urandom);
    chk({tag, " in_ready busy"}, in_ready, 0);
    cnt = 0;
    while (!out_valid && cnt < 40) begin @(negedge clk); cnt++; end
    chk({tag, " latency"}, cnt, W);
    chk({tag, " data"}, out_data, e);
    chk({tag, " negzero"}, out_negzero, enz);
    chk({tag, " ovf"}, out_ovf, eov);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold valid"}, out_valid, 1);
      chk({tag, " hold data"}, {out_negzero, out_ovf, out_data}, {enz, eov, e});
      chk({tag, " hold in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " valid drop"}, out_valid, 0);
    chk({tag, " in_ready back"}, in_ready, 1);
    chk({tag, " data kept"}, out_data, e);
    $display("w8 %s mode=%0d in=%02h out=%02h nz=%0d ovf=%0d exp=%02h/%0d/%0d",
             tag, m, d, out_data, out_negzero, out_ovf, e, enz, eov);
  endtask

  task automatic run4(input logic [3:0] d, input logic m);
    int cnt;
    logic enz, eov;
    logic [3:0] e;
    e = 4'(model(4, longint'(d), m, enz, eov));
    cnt = 0;
    while (!in_ready_4 && cnt < 20) begin @(negedge clk); cnt++; end
    in_data_4 = d; in_mode_4 = m; in_valid_4 = 1'b1;
    @(negedge clk);
    in_valid_4 = 1'b0;
    cnt = 0;
    while (!out_valid_4 && cnt < 40) begin @(negedge clk); cnt++; end
    chk("w4 latency", cnt, 4);
    chk("w4 result", {out_negzero_4, out_ovf_4, out_data_4}, {enz, eov, e});
    out_ready_4 = 1'b1;
    @(negedge clk);
    out_ready_4 = 1'b0;
    chk("w4 valid drop", out_valid_4, 0);
    $display("w4 mode=%0d in=%h out=%h nz=%0d ovf=%0d exp=%h/%0d/%0d",
             m, d, out_data_4, out_negzero_4, out_ovf_4, e, enz, eov);
  endtask

  typedef struct {
    logic [W-1:0] d;
    logic         m;
    int           hold;
    logic [W-1:0] e;
    logic         nz;
    logic         ov;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [W-1:0] x, e1;
    logic m, nz, ov, bad;

    vecs[0] = '{8'h85, 1'b0, 0, 8'hFB, 1'b0, 1'b0};
    vecs[1] = '{8'hFB, 1'b1, 0, 8'h85, 1'b0, 1'b0};
    vecs[2] = '{8'h05, 1'b1, 0, 8'h05, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 0, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 5, 8'hFF, 1'b0, 1'b1};
    vecs[6] = '{8'h7F, 1'b0, 0, 8'h7F, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b0;
    in_valid_4 = 1'b0; in_data_4 = '0; in_mode_4 = 1'b0; out_ready_4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset in_ready", in_ready, 0);
    chk("reset outputs", {out_valid, out_negzero, out_ovf, out_data}, 0);
    rst = 1'b0;
    #1;
    chk("release in_ready", in_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run8(vecs[i].d, vecs[i].m, vecs[i].hold, vecs[i].e, vecs[i].nz, vecs[i].ov, "table");

    // Abort mid-conversion: reset lands in the third CONV cycle
    in_data = 8'h85; in_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort in_ready low", in_ready, 0);
    chk("abort valid low", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort in_ready high", in_ready, 1);
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    chk("abort no output", bad, 0);
    run8(8'h83, 1'b0, 0, 8'hFD, 1'b0, 1'b0, "post-abort");

    for (int i = 0; i < 30; i++) begin
      x  = W'($urandom);
      m  = 1'($urandom);
      e1 = W'(model(W, longint'(x), m, nz, ov));
      run8(x, m, 0, e1, nz, ov, "rand");
      if (!(x[W-1] && x[W-2:0] == '0))
        run8(e1, !m, 0, x, 1'b0, 1'b0, "inverse");
    end

    for (int v = 0; v < 16; v++)
      for (int mm = 0; mm < 2; mm++)
        run4(4'(v), 1'(mm));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
